btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Sequences writes into the 4-way, 16-set branch target buffer datapath.
- Accepts resolved-branch updates from the MEM stage into a small update queue.
- Drains the queue onto the BTB write port one entry per cycle, deferring writes that would hit the set index fetch is reading that cycle.
- A starvation limit bounds how long a deferred write can wait.

Parameters:
- DEPTH, 4: update queue entries (power of two, 2..16).
- MAX_DEFER, 3: consecutive deferred cycles after which the head write is forced regardless of conflict.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  MEM-stage resolved branch present
- upd_ready  out  1  queue can accept (registered, = !full)
- upd_pc  in  16  branch PC
- upd_target  in  16  resolved target
- upd_taken  in  1  branch taken
- upd_uc  in  1  unconditional branch
- fetch_valid  in  1  fetch is reading the BTB this cycle
- fetch_pc  in  16  fetch PC
- flush  in  1  synchronous queue clear
- btb_index_fetch  out  4  fetch_pc[3:0]
- btb_tag_fetch  out  12  fetch_pc[15:4]
- btb_write  out  1  write strobe to the BTB
- btb_uc  out  1  head uc bit
- btb_index_mem  out  4  head pc[3:0]
- btb_tag_mem  out  12  head pc[15:4]
- btb_target  out  16  head target
- q_count  out  log2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst_n low, async): queue empty, q_count=0, upd_ready=1, state IDLE, defer counter 0, btb_write=0.
- btb_index_fetch and btb_tag_fetch are purely combinational slices of fetch_pc.
- Enqueue: occurs when upd_valid & upd_ready & upd_taken. Handshakes with upd_taken=0 complete without an entry (not-taken branches never allocate).
- Merge: if an enqueue's pc equals the tail entry's pc, and the tail is not the head being written this cycle, overwrite the tail's target and uc. No new entry is created.
- upd_ready is derived from registered occupancy. When full, ready stays 0 even if a dequeue happens in the same cycle.
- btb_index_mem, btb_tag_mem, btb_target and btb_uc always reflect the head entry (don't-care when empty).
- Conflict definition: conflict = fetch_valid & (fetch_pc[3:0] == head pc[3:0]).
- State IDLE (queue empty): btb_write=0. Go to ISSUE when an entry is enqueued; the first write is possible the following cycle.
- State ISSUE:
  - No conflict: btb_write=1 and the head dequeues at the clock edge.
  - Conflict: btb_write=0, defer counter becomes 1, go to DEFER.
  - Go to IDLE when the last entry dequeues with no enqueue that cycle.
- State DEFER:
  - No conflict, or defer counter == MAX_DEFER: btb_write=1 (forced write), dequeue, counter cleared, go to ISSUE or IDLE.
  - Otherwise: btb_write=0, counter increments.
- btb_write is combinational from state, head-valid and conflict. It is never asserted while the queue is empty.
- Simultaneous enqueue and dequeue: q_count is unchanged and pointers wrap modulo DEPTH.
- Flush:
  - Sets btb_write=0 in the flush cycle.
  - Empties the queue and returns to IDLE at the next edge.
  - Any enqueue in the flush cycle is dropped.
- Reset mid-drain: all queued updates are discarded. No partial write is issued.

Optional Feature:
- Macro BTB_UPDATE_STATS_EN.
- When defined, three 16-bit saturating counters are exposed:
  - stat_writes: increments on each btb_write.
  - stat_defers: increments on each deferred cycle.
  - stat_forced: increments on each forced write at MAX_DEFER.
- All three are cleared by rst_n only, not by flush.
- When undefined, these ports and registers do not exist; functionality is otherwise identical.

Test Plan:
- Single write: reset, enqueue pc=0x1234, target=0x2000, taken=1, uc=0, fetch_valid=0. Next cycle: btb_write=1, index_mem=4, tag_mem=0x123, target=0x2000. q_count then returns to 0.
- Not-taken drop: enqueue pc=0x0040 with taken=0 -> upd_ready stays 1, q_count stays 0, btb_write is never asserted.
- Deferral and force: queue pc=0x0105 while fetch_valid=1, fetch_pc=0x3335 (index 5 matches) held continuously. btb_write stays 0 for 3 cycles, is forced on the 4th, and the forced count increments if BTB_UPDATE_STATS_EN is defined.
- Full/backpressure: with DEPTH=4 and fetch conflicting, enqueue 4 distinct pcs -> upd_ready=0, q_count=4. Remove the conflict: the 4 writes appear in FIFO order on consecutive cycles and upd_ready returns to 1 after the first dequeue.
- Merge: enqueue pc=0x0200 with target 0x0300, then the same pc with target 0x0400 while the head is deferred -> q_count=1 and the eventual write carries target 0x0400.
- Flush and async reset: fill 3 entries, assert flush -> no write, q_count=0 next cycle. Refill, pull rst_n low mid-cycle -> q_count=0 and btb_write=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: queues resolved taken branches and drains them onto the BTB write port,
// deferring writes that collide with the fetch read index. Optional counters: `BTB_UPDATE_STATS_EN.
module btb_update_ctrl #(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [15:0]              upd_pc,
    input  logic [15:0]              upd_target,
    input  logic                     upd_taken,
    input  logic                     upd_uc,
    input  logic                     fetch_valid,
    input  logic [15:0]              fetch_pc,
    input  logic                     flush,
    output logic [3:0]               btb_index_fetch,
    output logic [11:0]              btb_tag_fetch,
    output logic                     btb_write,
    output logic                     btb_uc,
    output logic [3:0]               btb_index_mem,
    output logic [11:0]              btb_tag_mem,
    output logic [15:0]              btb_target,
`ifdef BTB_UPDATE_STATS_EN
    output logic [15:0]              stat_writes,
    output logic [15:0]              stat_defers,
    output logic [15:0]              stat_forced,
`endif
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(MAX_DEFER + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DEFER} state_t;

    state_t         state_q, state_d;
    logic [15:0]    pc_mem  [DEPTH];
    logic [15:0]    tgt_mem [DEPTH];
    logic           uc_mem  [DEPTH];
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d, tail_last;
    logic [AW:0]    count_q, count_d;
    logic [DW-1:0]  defer_q, defer_d;
    logic           head_valid, conflict, at_limit, issue_ok;
    logic           enq_hs, merge, push, deq, last_out;

    assign btb_index_fetch = fetch_pc[3:0];
    assign btb_tag_fetch   = fetch_pc[15:4];

    assign btb_index_mem = pc_mem[head_q][3:0];
    assign btb_tag_mem   = pc_mem[head_q][15:4];
    assign btb_target    = tgt_mem[head_q];
    assign btb_uc        = uc_mem[head_q];

    assign head_valid = (count_q != '0);
    assign upd_ready  = (count_q != (AW+1)'(DEPTH));
    assign q_count    = count_q;
    assign tail_last  = tail_q - AW'(1);

    assign conflict = fetch_valid & (fetch_pc[3:0] == pc_mem[head_q][3:0]);
    assign at_limit = (defer_q == DW'(MAX_DEFER));

    assign issue_ok  = ((state_q == S_ISSUE) & ~conflict) |
                       ((state_q == S_DEFER) & (~conflict | at_limit));
    assign btb_write = ~flush & head_valid & issue_ok;
    assign deq       = btb_write;

    // The tail may absorb a repeat update unless it is the lone entry leaving this cycle.
    assign enq_hs   = upd_valid & upd_ready & upd_taken & ~flush;
    assign merge    = enq_hs & head_valid & (pc_mem[tail_last] == upd_pc) &
                      ~((count_q == (AW+1)'(1)) & deq);
    assign push     = enq_hs & ~merge;
    assign last_out = (count_q == (AW+1)'(1)) & ~push;

    always_comb begin
        state_d = state_q;
        defer_d = defer_q;
        if (flush) begin
            state_d = S_IDLE;
            defer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (push) state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (!head_valid) begin
                        state_d = push ? S_ISSUE : S_IDLE;
                    end else if (conflict) begin
                        defer_d = DW'(1);
                        state_d = S_DEFER;
                    end else if (last_out) begin
                        state_d = S_IDLE;
                    end
                end
                S_DEFER: begin
                    if (!head_valid) begin
                        defer_d = '0;
                        state_d = push ? S_ISSUE : S_IDLE;
                    end else if (btb_write) begin
                        defer_d = '0;
                        state_d = last_out ? S_IDLE : S_ISSUE;
                    end else begin
                        defer_d = defer_q + DW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    defer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (deq)  head_d = head_q + AW'(1);
            case ({push, deq})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            defer_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            defer_q <= defer_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]  <= upd_pc;
            tgt_mem[tail_q] <= upd_target;
            uc_mem[tail_q]  <= upd_uc;
        end else if (merge) begin
            tgt_mem[tail_last] <= upd_target;
            uc_mem[tail_last]  <= upd_uc;
        end
    end

`ifdef BTB_UPDATE_STATS_EN
    logic [15:0] stat_writes_q, stat_defers_q, stat_forced_q;
    logic        defer_cyc, forced;

    assign defer_cyc = ~flush & head_valid & ((state_q == S_ISSUE) | (state_q == S_DEFER)) &
                       conflict & ~btb_write;
    assign forced    = btb_write & conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_writes_q <= '0;
            stat_defers_q <= '0;
            stat_forced_q <= '0;
        end else begin
            if (btb_write && stat_writes_q != 16'hFFFF) stat_writes_q <= stat_writes_q + 16'd1;
            if (defer_cyc && stat_defers_q != 16'hFFFF) stat_defers_q <= stat_defers_q + 16'd1;
            if (forced && stat_forced_q != 16'hFFFF)    stat_forced_q <= stat_forced_q + 16'd1;
        end
    end

    assign stat_writes = stat_writes_q;
    assign stat_defers = stat_defers_q;
    assign stat_forced = stat_forced_q;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: a scoreboard queue holds expected BTB writes, a negedge
// monitor checks each asserted btb_write against it; stimulus checks occupancy and strobe timing.
module tb_btb_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        upd_uc;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic        flush;
    logic [3:0]  btb_index_fetch;
    logic [11:0] btb_tag_fetch;
    logic        btb_write;
    logic        btb_uc;
    logic [3:0]  btb_index_mem;
    logic [11:0] btb_tag_mem;
    logic [15:0] btb_target;
    logic [2:0]  q_count;
`ifdef BTB_UPDATE_STATS_EN
    logic [15:0] stat_writes, stat_defers, stat_forced;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];   // {pc, target, uc}

    btb_update_ctrl #(.DEPTH(4), .MAX_DEFER(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .upd_uc          (upd_uc),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .flush           (flush),
        .btb_index_fetch (btb_index_fetch),
        .btb_tag_fetch   (btb_tag_fetch),
        .btb_write       (btb_write),
        .btb_uc          (btb_uc),
        .btb_index_mem   (btb_index_mem),
        .btb_tag_mem     (btb_tag_mem),
        .btb_target      (btb_target),
`ifdef BTB_UPDATE_STATS_EN
        .stat_writes     (stat_writes),
        .stat_defers     (stat_defers),
        .stat_forced     (stat_forced),
`endif
        .q_count         (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic [15:0] pc, input logic [15:0] tgt,
                             input logic taken, input logic uc);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = taken;
        upd_uc     = uc;
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected update.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && btb_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got pc %h target %h, required no write",
                         {btb_tag_mem, btb_index_mem}, btb_target);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({btb_tag_mem, btb_index_mem, btb_target, btb_uc} !== e) begin
                    n_err++;
                    $display("FAIL write_data: got pc %h tgt %h uc %b, required pc %h tgt %h uc %b",
                             {btb_tag_mem, btb_index_mem}, btb_target, btb_uc,
                             e[32:17], e[16:1], e[0]);
                end else begin
                    $display("ok   write pc %h tgt %h uc %b", e[32:17], e[16:1], e[0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        upd_uc = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
        #2;
        chk("reset_q_count", 32'(q_count), 32'd0);
        chk("reset_ready", 32'(upd_ready), 32'd1);
        chk("reset_write", 32'(btb_write), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single write
        drive_upd(16'h1234, 16'h2000, 1'b1, 1'b0);
        exp_q.push_back({16'h1234, 16'h2000, 1'b0});
        cyc();
        upd_valid = 1'b0;
        #1;
        chk("single_q_count", 32'(q_count), 32'd1);
        chk("single_write", 32'(btb_write), 32'd1);
        chk("fetch_slice", 32'({btb_tag_fetch, btb_index_fetch}), 32'(fetch_pc));
        cyc();
        #1;
        chk("single_drained", 32'(q_count), 32'd0);

        // Not-taken update never allocates
        drive_upd(16'h0040, 16'h0050, 1'b0, 1'b0);
        cyc();
        upd_valid = 1'b0;
        #1;
        chk("nt_ready", 32'(upd_ready), 32'd1);
        chk("nt_q_count", 32'(q_count), 32'd0);
        chk("nt_write", 32'(btb_write), 32'd0);

        // Deferral then forced write on the 4th cycle
        fetch_valid = 1'b1;
        fetch_pc    = 16'h3335;
        drive_upd(16'h0105, 16'h0AAA, 1'b1, 1'b1);
        exp_q.push_back({16'h0105, 16'h0AAA, 1'b1});
        cyc();
        upd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("defer_%0d_write", k), 32'(btb_write), 32'd0);
            cyc();
        end
        #1;
        chk("forced_write", 32'(btb_write), 32'd1);
        cyc();
        #1;
        chk("forced_drained", 32'(q_count), 32'd0);
`ifdef BTB_UPDATE_STATS_EN
        chk("stat_forced_1", 32'(stat_forced), 32'd1);
`endif

        // Fill to full under conflict, then drain in order
        fetch_pc = 16'h0007;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] pc;
            pc = 16'h1007 + 16'(i) * 16'h1001;
            drive_upd(pc, 16'h0A01 + 16'(i), 1'b1, 1'(i & 1));
            exp_q.push_back({pc, 16'h0A01 + 16'(i), 1'(i & 1)});
            cyc();
        end
        fetch_valid = 1'b0;
        drive_upd(16'h500B, 16'h0A05, 1'b1, 1'b0);
        #1;
        chk("full_q_count", 32'(q_count), 32'd4);
        chk("full_ready", 32'(upd_ready), 32'd0);
        chk("full_drain0", 32'(btb_write), 32'd1);
        cyc();
        upd_valid = 1'b0;
        #1;
        chk("full_q_after1", 32'(q_count), 32'd3);
        chk("full_ready_back", 32'(upd_ready), 32'd1);
        chk("full_drain1", 32'(btb_write), 32'd1);
        cyc();
        #1;
        chk("full_drain2", 32'(btb_write), 32'd1);
        cyc();
        #1;
        chk("full_drain3", 32'(btb_write), 32'd1);
        cyc();
        #1;
        chk("full_drained", 32'(q_count), 32'd0);

        // Merge into a deferred head
        fetch_valid = 1'b1;
        fetch_pc    = 16'h0000;
        drive_upd(16'h0200, 16'h0300, 1'b1, 1'b0);
        cyc();
        drive_upd(16'h0200, 16'h0400, 1'b1, 1'b1);
        exp_q.push_back({16'h0200, 16'h0400, 1'b1});
        cyc();
        upd_valid   = 1'b0;
        fetch_valid = 1'b0;
        #1;
        chk("merge_q_count", 32'(q_count), 32'd1);
        cyc();
        #1;
        chk("merge_drained", 32'(q_count), 32'd0);

        // Flush with an enqueue in the flush cycle
        fetch_valid = 1'b1;
        fetch_pc    = 16'h000F;
        drive_upd(16'h001F, 16'h0B01, 1'b1, 1'b0);
        cyc();
        drive_upd(16'h002E, 16'h0B02, 1'b1, 1'b0);
        cyc();
        drive_upd(16'h003D, 16'h0B03, 1'b1, 1'b0);
        cyc();
        drive_upd(16'h004C, 16'h0B04, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_q_before", 32'(q_count), 32'd3);
        chk("flush_write", 32'(btb_write), 32'd0);
        cyc();
        flush       = 1'b0;
        upd_valid   = 1'b0;
        fetch_valid = 1'b0;
        #1;
        chk("flush_q_count", 32'(q_count), 32'd0);
        chk("flush_after_write", 32'(btb_write), 32'd0);
`ifdef BTB_UPDATE_STATS_EN
        chk("stat_writes", 32'(stat_writes), 32'd7);
        chk("stat_defers", 32'(stat_defers), 32'd9);
`endif
        cyc();

        // Asynchronous reset mid-drain
        fetch_valid = 1'b1;
        drive_upd(16'h005F, 16'h0C01, 1'b1, 1'b0);
        cyc();
        drive_upd(16'h006F, 16'h0C02, 1'b1, 1'b0);
        cyc();
        upd_valid = 1'b0;
        #1;
        chk("refill_q_count", 32'(q_count), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_q_count", 32'(q_count), 32'd0);
        chk("areset_write", 32'(btb_write), 32'd0);
        chk("areset_ready", 32'(upd_ready), 32'd1);
`ifdef BTB_UPDATE_STATS_EN
        chk("areset_stat_writes", 32'(stat_writes), 32'd0);
`endif
        cyc();
        rst_n       = 1'b1;
        fetch_valid = 1'b0;
        cyc();
        #1;
        chk("post_reset_write", 32'(btb_write), 32'd0);
        chk("post_reset_q_count", 32'(q_count), 32'd0);
        cyc();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
